// File: rtl/adc_spi_resp.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// adc_spi_resp
//
// SPI responder that stands in for the 8-channel, 12-bit SPI A2D converter so
// the round-robin A2D interface can be simulated or FPGA-looped without the
// real part. SS_n, SCLK and MOSI are oversampled in the clk domain. Each
// frame captures a 16-bit command from MOSI. In the same frame, MISO shifts
// out the conversion for the channel that the previous frame addressed.
//
// SPI mode: SCLK idles high. The monarch changes MOSI on the falling edge and
// samples on the rising edge, so this block samples MOSI on SCLK rise and
// advances MISO on SCLK fall. The monarch drops SCLK once before its first
// rise (front porch). That falling edge must not shift, because the MSB is
// already on MISO.
//
// Ports
//   clk        : system clock
//   rst_n      : asynchronous active-low reset
//   SS_n       : serf select, active low, frames a transfer
//   SCLK       : serial clock, idle high, each phase >= 8 clk
//   MOSI       : command bits from the monarch, MSB first
//   MISO       : response bits to the monarch, MSB first, 0 outside a frame
//   req_chnl   : channel whose conversion goes out in the next frame
//   conv_data  : conversion value for req_chnl, sampled when the frame starts
//   cmd_chnl   : channel field (bits 13:11) of the last complete command
//   frame_done : one-clk pulse when a frame of exactly FRAME_BITS bits ends
//   frame_err  : one-clk pulse when a frame ends with any other bit count
// -----------------------------------------------------------------------------
module adc_spi_resp #(
    parameter int         FRAME_BITS = 16,
    parameter logic [2:0] RST_CHNL   = 3'b000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    output logic [2:0]  req_chnl,
    input  logic [11:0] conv_data,
    output logic [2:0]  cmd_chnl,
    output logic        frame_done,
    output logic        frame_err
);

    // The counter saturates at FRAME_BITS+1, which is enough to flag long frames.
    localparam int             CNT_W    = $clog2(FRAME_BITS + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACTIVE = 2'b01,
        DONE   = 2'b10
    } state_t;

    state_t state, nxt_state;

    // ------------------------------------------------------------------
    // Input synchronizers. SS_n and SCLK get a third flop for edge
    // detection. Their reset value is 1, so a reset does not look like a
    // falling edge on an idle bus.
    // ------------------------------------------------------------------
    logic [2:0] ss_sync;
    logic [2:0] sclk_sync;
    logic [1:0] mosi_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_sync   <= 3'b111;
            sclk_sync <= 3'b111;
            mosi_sync <= 2'b00;
        end else begin
            ss_sync   <= {ss_sync[1:0],   SS_n};
            sclk_sync <= {sclk_sync[1:0], SCLK};
            mosi_sync <= {mosi_sync[0],   MOSI};
        end
    end

    logic ss_fall, ss_rise, sclk_rise, sclk_fall;

    assign ss_fall   =  ss_sync[2]   & ~ss_sync[1];
    assign ss_rise   = ~ss_sync[2]   &  ss_sync[1];
    assign sclk_rise = ~sclk_sync[2] &  sclk_sync[1];
    assign sclk_fall =  sclk_sync[2] & ~sclk_sync[1];

    // ------------------------------------------------------------------
    // Datapath state
    // ------------------------------------------------------------------
    logic [15:0]      tx_shft;
    // Only command bits 13:11 matter. After a full 16-bit frame they sit in
    // bits 13:11 of this register; bits 15:14 have already shifted out the top.
    logic [13:0]      rx_shft;
    logic [CNT_W-1:0] bit_cnt;
    logic             first_rise;

    // FSM control strobes
    logic ld_tx;
    logic do_rx;
    logic do_tx;
    logic commit;
    logic err;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt_state;
    end

    // ------------------------------------------------------------------
    // FSM: next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        nxt_state = state;
        MISO      = 1'b0;
        ld_tx     = 1'b0;
        do_rx     = 1'b0;
        do_tx     = 1'b0;
        commit    = 1'b0;
        err       = 1'b0;
        case (state)
            IDLE: begin
                if (ss_fall) begin
                    ld_tx     = 1'b1;
                    nxt_state = ACTIVE;
                end
            end
            ACTIVE: begin
                MISO = tx_shft[15];
                // If ss_rise arrives in the same clk as sclk_rise, the
                // sample is still taken here. DONE then sees the updated
                // count and shift register.
                if (sclk_rise)               do_rx = 1'b1;
                if (sclk_fall && first_rise) do_tx = 1'b1;
                if (ss_rise)                 nxt_state = DONE;
            end
            DONE: begin
                // An ss_fall that lands here is dropped on purpose. The
                // monarch must keep SS_n high long enough between frames.
                nxt_state = IDLE;
                if (bit_cnt == CNT_FULL) commit = 1'b1;
                else                     err    = 1'b1;
            end
            default: nxt_state = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Shift registers, bit counter, front-porch flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_shft    <= 16'h0000;
            rx_shft    <= 14'h0000;
            bit_cnt    <= '0;
            first_rise <= 1'b0;
        end else begin
            if (ld_tx) begin
                tx_shft    <= {4'h0, conv_data};
                bit_cnt    <= '0;
                first_rise <= 1'b0;
            end else begin
                if (do_rx) begin
                    rx_shft    <= {rx_shft[12:0], mosi_sync[1]};
                    first_rise <= 1'b1;
                    if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + 1'b1;
                end
                // Zeros fill from the bottom, so clocks past the 16th read 0.
                if (do_tx) tx_shft <= {tx_shft[14:0], 1'b0};
            end
        end
    end

    // ------------------------------------------------------------------
    // Command result and frame status pulses
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_chnl   <= 3'b000;
            req_chnl   <= RST_CHNL;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            frame_done <= commit;
            frame_err  <= err;
            if (commit) begin
                cmd_chnl <= rx_shft[13:11];
                req_chnl <= rx_shft[13:11];
            end
        end
    end

endmodule

// File: doc/adc_spi_resp.md
Name: adc_spi_resp

Overview:
- SPI responder (serf) that emulates the 8-channel, 12-bit SPI A2D converter for the A2D round-robin interface.
- Lets that interface be simulated and FPGA-looped without the real part.
- Oversamples SS_n/SCLK/MOSI in the clk domain, captures a 16-bit command per frame, and shifts out on MISO the 12-bit conversion for the channel addressed in the previous frame.
- The conversion value comes from the environment via a request/data pair.

Parameters:
- FRAME_BITS, 16, SCLK rising edges in a complete frame.
- RST_CHNL, 3'b000, channel pointer value after reset.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- SS_n, input, 1, serf select, active low; framing.
- SCLK, input, 1, serial clock; idle high; at most clk/16.
- MOSI, input, 1, command data from the monarch.
- MISO, output, 1, response data to the monarch.
- req_chnl, output, 3, channel whose conversion goes out in the next frame.
- conv_data, input, 12, conversion value for req_chnl; sampled at frame start.
- cmd_chnl, output, 3, channel field of the last complete command.
- frame_done, output, 1, one-clk pulse when a complete frame ends.
- frame_err, output, 1, one-clk pulse when a frame ends with a bit count other than FRAME_BITS.

Behaviour:
- Reset values:
  - MISO=0, req_chnl=RST_CHNL, cmd_chnl=0, frame_done=0, frame_err=0.
  - Shift registers cleared; bit count = 0; state IDLE.
  - SS_n/SCLK synchronizers preset to 1; MOSI synchronizer cleared.
- Synchronization:
  - SS_n, SCLK and MOSI each pass through a 2-flop synchronizer.
  - A third flop on SS_n and SCLK provides edge detect: ss_fall, ss_rise, sclk_rise, sclk_fall.
  - Edge-to-action latency is 3 clk. SCLK high/low phases must be ≥8 clk.
- State IDLE:
  - MISO=0.
  - On ss_fall: load tx_shft = {4'h0, conv_data}; clear bit count and the first-rise flag; go to ACTIVE.
- State ACTIVE:
  - MISO = tx_shft[15].
  - On sclk_rise: rx_shft <= {rx_shft[14:0], MOSI_sync}; bit count += 1 (saturates at FRAME_BITS+1); set the first-rise flag.
  - On sclk_fall, only if the first-rise flag is set: tx_shft <= {tx_shft[14:0], 1'b0}.
    - The sclk_fall before the first rise (monarch front porch) does not shift.
  - On ss_rise: go to DONE.
- State DONE (one clk), then IDLE:
  - Bit count == FRAME_BITS:
    - cmd_chnl <= rx_shft[13:11]; req_chnl <= rx_shft[13:11].
    - Pulse frame_done.
  - Bit count != FRAME_BITS (short or long frame):
    - Pulse frame_err.
    - cmd_chnl and req_chnl unchanged.
- Command bits 15:14 and 10:0 are ignored; no check on their value.
- Data ordering: frame N returns the data for the channel commanded in frame N-1. The first frame after reset returns channel RST_CHNL.
- After 16 shifts tx_shft is all zero, so extra SCLK cycles produce MISO=0.
- Simultaneous events:
  - ss_rise in the same clk as sclk_rise: process the sample first, then end the frame.
  - ss_fall while in DONE: ignored; the monarch must hold SS_n high ≥4 clk between frames.
- conv_data is sampled only on ss_fall; changes mid-frame have no effect.
- Reset asserted mid-frame: immediate return to reset values; the next frame is treated as the first frame after reset.

Test Plan:
- Reset, conv_data=12'hA5C, one 16-bit frame with MOSI=16'h2000 (chnl 3'b100) -> MISO shifts 16'h0A5C MSB first; frame_done pulse; cmd_chnl=req_chnl=3'b100.
- Two back-to-back frames with commands chnl 5 then chnl 6, conv_data following req_chnl (ch5=12'h123, ch6=12'h456) -> frame 2 returns 16'h0123; afterwards req_chnl=6.
- Connect to the A2D interface with SPI_mnrch: four nxt pulses, model values L=12'h111, R=12'h222, steer=12'h333, batt=12'h444 -> lft_ld, rght_ld, steer_pot and batt equal those values after the respective second transaction.
- Short frame (SS_n raised after 9 SCLK) -> frame_err pulse, no frame_done, req_chnl unchanged; the next full frame returns the old channel's data.
- Long frame (18 SCLK) -> frame_err pulse; MISO=0 on bits 17-18.
- rst_n asserted at bit 7 of a frame -> MISO=0 immediately, req_chnl=0; the next full frame returns the channel-0 value.
